// File: rtl/riscv_operand_fetch_if.sv
// Instruction, ALU-operand and writeback signals of the operand-fetch stage.
// The upstream/ALU side uses the master modport; the stage itself uses slave.
interface riscv_operand_fetch_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    // Instruction handshake
    logic                  instruction_valid;
    logic [31:0]           instruction;
    logic                  instruction_ready;

    // Issued operands towards the ALU
    logic                  enable;
    logic [2:0]            funct3;
    logic                  funct7_bit5;
    logic [DATA_WIDTH-1:0] register_data_1;
    logic [DATA_WIDTH-1:0] register_data_2;
    logic [4:0]            destination_register;
    logic                  illegal_instruction;

    // Result coming back from the ALU stage
    logic                  writeback_enable;
    logic [4:0]            writeback_register;
    logic [DATA_WIDTH-1:0] writeback_data;

    modport master (
        output instruction_valid,
        output instruction,
        input  instruction_ready,
        input  enable,
        input  funct3,
        input  funct7_bit5,
        input  register_data_1,
        input  register_data_2,
        input  destination_register,
        input  illegal_instruction,
        output writeback_enable,
        output writeback_register,
        output writeback_data
    );

    modport slave (
        input  instruction_valid,
        input  instruction,
        output instruction_ready,
        output enable,
        output funct3,
        output funct7_bit5,
        output register_data_1,
        output register_data_2,
        output destination_register,
        output illegal_instruction,
        input  writeback_enable,
        input  writeback_register,
        input  writeback_data
    );

endinterface

// File: rtl/riscv_operand_fetch.sv
// RV32I decode and operand-fetch stage: decodes OP / OP-IMM words, reads the
// register file it owns (with writeback bypass), tracks outstanding results in
// a pending scoreboard and presents registered operands to the ALU.
module riscv_operand_fetch #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REGISTER_COUNT = 32
) (
    input logic                  clock,
    input logic                  reset_n,
    riscv_operand_fetch_if.slave bus
);

    localparam logic [6:0] OpcodeOp    = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm = 7'b0010011;
    localparam logic [6:0] Funct7Base  = 7'b0000000;
    localparam logic [6:0] Funct7Alt   = 7'b0100000;
    localparam logic [2:0] Funct3Add   = 3'b000;
    localparam logic [2:0] Funct3Sll   = 3'b001;
    localparam logic [2:0] Funct3Srx   = 3'b101;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] field_funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] field_funct7;

    assign opcode       = bus.instruction[6:0];
    assign rd           = bus.instruction[11:7];
    assign field_funct3 = bus.instruction[14:12];
    assign rs1          = bus.instruction[19:15];
    assign rs2          = bus.instruction[24:20];
    assign field_funct7 = bus.instruction[31:25];

    // Architectural state
    logic [DATA_WIDTH-1:0]     regs_q [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] pending_q;
    logic [REGISTER_COUNT-1:0] pending_d;

    // Registered ALU-facing outputs
    logic                  enable_q,      enable_d;
    logic                  illegal_q,     illegal_d;
    logic [2:0]            funct3_q,      funct3_d;
    logic                  funct7_bit5_q, funct7_bit5_d;
    logic [DATA_WIDTH-1:0] operand_1_q,   operand_1_d;
    logic [DATA_WIDTH-1:0] operand_2_q,   operand_2_d;
    logic [4:0]            destination_q, destination_d;

    // Decode results
    logic                  is_r_type;
    logic                  is_i_type;
    logic                  legal;
    logic                  uses_rs2;
    logic                  decoded_funct7_bit5;
    logic [DATA_WIDTH-1:0] immediate;

    // Hazard / handshake
    logic rs1_busy;
    logic rs2_busy;
    logic rd_busy;
    logic hazard;
    logic ready;
    logic transfer;
    logic issue;

    // Operand read path
    logic                  bypass_1;
    logic                  bypass_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  regfile_write;

    // Decode legality, operand-2 source and the SUB/SRA modifier
    always_comb begin
        is_r_type           = (opcode == OpcodeOp);
        is_i_type           = (opcode == OpcodeOpImm);
        legal               = 1'b0;
        uses_rs2            = 1'b0;
        decoded_funct7_bit5 = 1'b0;
        immediate           = {{(DATA_WIDTH-12){bus.instruction[31]}}, bus.instruction[31:20]};
        if (is_r_type) begin
            uses_rs2            = 1'b1;
            decoded_funct7_bit5 = bus.instruction[30];
            legal = (field_funct7 == Funct7Base) ||
                    ((field_funct7 == Funct7Alt) &&
                     ((field_funct3 == Funct3Add) || (field_funct3 == Funct3Srx)));
        end else if (is_i_type) begin
            unique case (field_funct3)
                Funct3Sll: begin
                    // Shift amount only; upper bits are an encoding field, not immediate
                    immediate           = {{(DATA_WIDTH-5){1'b0}}, bus.instruction[24:20]};
                    decoded_funct7_bit5 = bus.instruction[30];
                    legal               = (field_funct7 == Funct7Base);
                end
                Funct3Srx: begin
                    immediate           = {{(DATA_WIDTH-5){1'b0}}, bus.instruction[24:20]};
                    decoded_funct7_bit5 = bus.instruction[30];
                    legal = (field_funct7 == Funct7Base) || (field_funct7 == Funct7Alt);
                end
                default: begin
                    legal = 1'b1;
                end
            endcase
        end
    end

    // Hazard detection: a writeback landing this cycle releases its register
    always_comb begin
        rs1_busy = pending_q[rs1] &&
                   !(bus.writeback_enable && (bus.writeback_register == rs1));
        rs2_busy = pending_q[rs2] &&
                   !(bus.writeback_enable && (bus.writeback_register == rs2));
        rd_busy  = (rd != 5'd0) && pending_q[rd] &&
                   !(bus.writeback_enable && (bus.writeback_register == rd));
        // Illegal words are consumed without waiting on the scoreboard
        hazard   = legal && (rs1_busy || (uses_rs2 && rs2_busy) || rd_busy);
        ready    = reset_n && !hazard;
        transfer = bus.instruction_valid && ready;
        issue    = transfer && legal;
    end

    assign bus.instruction_ready = ready;

    // Register read with same-cycle writeback bypass; x0 is hardwired to zero
    always_comb begin
        bypass_1    = bus.writeback_enable && (bus.writeback_register == rs1);
        bypass_2    = bus.writeback_enable && (bus.writeback_register == rs2);
        read_data_1 = '0;
        read_data_2 = '0;
        if (rs1 != 5'd0) begin
            read_data_1 = bypass_1 ? bus.writeback_data : regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            read_data_2 = bypass_2 ? bus.writeback_data : regs_q[rs2];
        end
    end

    // Next-state of the ALU-facing outputs; fields hold while nothing issues
    always_comb begin
        enable_d      = issue;
        illegal_d     = transfer && !legal;
        funct3_d      = funct3_q;
        funct7_bit5_d = funct7_bit5_q;
        operand_1_d   = operand_1_q;
        operand_2_d   = operand_2_q;
        destination_d = destination_q;
        if (issue) begin
            funct3_d      = field_funct3;
            funct7_bit5_d = decoded_funct7_bit5;
            operand_1_d   = read_data_1;
            operand_2_d   = uses_rs2 ? read_data_2 : immediate;
            destination_d = rd;
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            enable_q      <= 1'b0;
            illegal_q     <= 1'b0;
            funct3_q      <= '0;
            funct7_bit5_q <= 1'b0;
            operand_1_q   <= '0;
            operand_2_q   <= '0;
            destination_q <= '0;
        end else begin
            enable_q      <= enable_d;
            illegal_q     <= illegal_d;
            funct3_q      <= funct3_d;
            funct7_bit5_q <= funct7_bit5_d;
            operand_1_q   <= operand_1_d;
            operand_2_q   <= operand_2_d;
            destination_q <= destination_d;
        end
    end

    assign bus.enable               = enable_q;
    assign bus.illegal_instruction  = illegal_q;
    assign bus.funct3               = funct3_q;
    assign bus.funct7_bit5          = funct7_bit5_q;
    assign bus.register_data_1      = operand_1_q;
    assign bus.register_data_2      = operand_2_q;
    assign bus.destination_register = destination_q;

    // Scoreboard next-state: writeback clears, issue sets, set wins on a tie
    always_comb begin
        pending_d = pending_q;
        if (bus.writeback_enable) begin
            pending_d[bus.writeback_register] = 1'b0;
        end
        if (issue && (rd != 5'd0)) begin
            pending_d[rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign regfile_write = bus.writeback_enable && (bus.writeback_register != 5'd0);

    // Register file; writes land whether or not the target was pending
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (regfile_write) begin
            regs_q[bus.writeback_register] <= bus.writeback_data;
        end
    end

endmodule

// File: tb/tb_riscv_operand_fetch.sv
// Bench for riscv_operand_fetch: directed scenarios plus random traffic, all
// compared cycle by cycle against a behavioural model of the stage.
module tb_riscv_operand_fetch;

    logic clock = 1'b0;
    logic reset_n;

    riscv_operand_fetch_if bus ();

    riscv_operand_fetch dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_regs [32];
    bit          m_pending [32];
    logic        m_enable;
    logic        m_illegal;
    logic [2:0]  m_funct3;
    logic        m_f7b5;
    logic [31:0] m_rd1;
    logic [31:0] m_rd2;
    logic [4:0]  m_dest;
    logic [4:0]  inflight [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // What the stage should make of a word, straight from the ISA subset rules
    function automatic void ref_decode(input logic [31:0] w, output bit legal, output bit is_r,
                                       output logic [31:0] imm, output bit f7b5);
        logic [6:0] hi;
        logic [2:0] f3;
        hi    = w[31:25];
        f3    = w[14:12];
        legal = 1'b0;
        is_r  = 1'b0;
        f7b5  = 1'b0;
        imm   = 32'($signed(w[31:20]));
        if (w[6:0] == 7'h33) begin
            is_r  = 1'b1;
            f7b5  = w[30];
            legal = (hi == 7'h00) || (hi == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (w[6:0] == 7'h13) begin
            legal = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                imm   = 32'(w[24:20]);
                f7b5  = w[30];
                legal = (hi == 7'h00) || (hi == 7'h20 && f3 == 3'd5);
            end
        end
    endfunction

    function automatic bit ref_busy(input logic [4:0] r, input bit we, input logic [4:0] wr);
        return m_pending[r] && !(we && wr == r);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r, input bit we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return m_regs[r];
    endfunction

    // One clock: check last edge's outputs, drive inputs, check ready, advance model
    task automatic step(input bit rst_in, input bit v, input logic [31:0] w, input bit we,
                        input logic [4:0] wr, input logic [31:0] wd, output bit accepted);
        bit          legal, is_r, f7b5, busy, exp_ready;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        @(negedge clock);
        check_eq("enable", 32'(bus.enable), 32'(m_enable));
        check_eq("illegal", 32'(bus.illegal_instruction), 32'(m_illegal));
        check_eq("funct3", 32'(bus.funct3), 32'(m_funct3));
        check_eq("funct7_bit5", 32'(bus.funct7_bit5), 32'(m_f7b5));
        check_eq("register_data_1", bus.register_data_1, m_rd1);
        check_eq("register_data_2", bus.register_data_2, m_rd2);
        check_eq("destination", 32'(bus.destination_register), 32'(m_dest));
        reset_n                = rst_in;
        bus.instruction_valid  = v;
        bus.instruction        = w;
        bus.writeback_enable   = we;
        bus.writeback_register = wr;
        bus.writeback_data     = wd;
        #1;
        ref_decode(w, legal, is_r, imm, f7b5);
        rd  = w[11:7];
        rs1 = w[19:15];
        rs2 = w[24:20];
        busy = ref_busy(rs1, we, wr) || (is_r && ref_busy(rs2, we, wr)) ||
               (rd != 5'd0 && ref_busy(rd, we, wr));
        exp_ready = rst_in && (!legal || !busy);
        check_eq("ready", 32'(bus.instruction_ready), 32'(exp_ready));
        accepted = v && exp_ready;
        if (!rst_in) begin
            m_enable = 0; m_illegal = 0; m_funct3 = 0; m_f7b5 = 0;
            m_rd1 = 0; m_rd2 = 0; m_dest = 0;
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_pending[i] = 0;
            end
            inflight.delete();
        end else begin
            m_enable  = accepted && legal;
            m_illegal = accepted && !legal;
            if (m_enable) begin
                m_funct3 = w[14:12];
                m_f7b5   = f7b5;
                m_rd1    = ref_read(rs1, we, wr, wd);
                m_rd2    = is_r ? ref_read(rs2, we, wr, wd) : imm;
                m_dest   = rd;
            end
            if (we) m_pending[wr] = 0;
            if (m_enable && rd != 5'd0) begin
                m_pending[rd] = 1;
                inflight.push_back(rd);
            end
            if (we && wr != 5'd0) m_regs[wr] = wd;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  hi;
        logic [11:0] imm;
        int unsigned k, p;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        p   = $urandom_range(0, 5);
        hi  = (p < 3) ? 7'h00 : (p < 5) ? 7'h20 : 7'($urandom);
        k   = $urandom_range(0, 9);
        if (k < 4) begin
            imm = 12'($urandom);
            if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = hi;
            return enc_i(imm, rs1, f3, rd);
        end
        if (k < 8) return enc_r(hi, rs2, rs1, f3, rd);
        if (k == 8) return $urandom;
        return {12'($urandom), rs1, 3'b010, rd, 7'b0000011};
    endfunction

    localparam logic [31:0] Addi = 32'hFFB00093;
    localparam logic [31:0] Sub  = 32'h402081B3;

    initial begin
        bit          acc, hold, rst, v, we;
        logic [31:0] w, prev_w, wd;
        logic [4:0]  wr;
        int          idx;

        m_enable = 0; m_illegal = 0; m_funct3 = 0; m_f7b5 = 0;
        m_rd1 = 0; m_rd2 = 0; m_dest = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_pending[i] = 0;
        end
        reset_n = 1'b0;
        bus.instruction_valid  = 1'b0;
        bus.instruction        = '0;
        bus.writeback_enable   = 1'b0;
        bus.writeback_register = '0;
        bus.writeback_data     = '0;
        @(posedge clock);
        @(posedge clock);

        // Fill the register file, then reset with traffic presented
        for (int r = 1; r < 32; r++) step(1, 0, 0, 1, 5'(r), $urandom, acc);
        step(0, 1, Addi, 1, 5'd7, 32'h1234, acc);
        step(0, 1, Addi, 0, 0, 0, acc);
        for (int i = 1; i < 32; i++) begin
            step(1, 1, enc_r(7'h00, 5'((i * 7) % 32), 5'(i), 3'd0, 5'd0), 0, 0, 0, acc);
        end

        // ADDI x1,x0,-5
        step(1, 1, Addi, 0, 0, 0, acc);
        @(posedge clock); #1;
        check_eq("addi_enable", 32'(bus.enable), 1);
        check_eq("addi_rd2", bus.register_data_2, 32'hFFFFFFFB);
        check_eq("addi_dest", 32'(bus.destination_register), 1);

        // SUB x3,x1,x2 stalls on x1 until its writeback, then issues with bypass
        step(1, 1, Sub, 0, 0, 0, acc);
        step(1, 1, Sub, 0, 0, 0, acc);
        step(1, 1, Sub, 1, 5'd1, 32'hFFFFFFFB, acc);
        check_eq("sub_ready_on_wb", 32'(acc), 1);
        @(posedge clock); #1;
        check_eq("sub_bypass", bus.register_data_1, 32'hFFFFFFFB);
        check_eq("sub_f7b5", 32'(bus.funct7_bit5), 1);

        // SRAI x4,x1,7 and an SLLI with bit 30 set
        step(1, 1, 32'h4070D213, 0, 0, 0, acc);
        @(posedge clock); #1;
        check_eq("srai_funct3", 32'(bus.funct3), 5);
        check_eq("srai_rd2", bus.register_data_2, 7);
        step(1, 1, enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd5), 0, 0, 0, acc);
        @(posedge clock); #1;
        check_eq("slli_illegal", 32'(bus.illegal_instruction), 1);
        check_eq("slli_no_enable", 32'(bus.enable), 0);

        // LW is consumed as illegal; the next word goes straight through
        step(1, 1, 32'h0000A083, 0, 0, 0, acc);
        step(1, 1, enc_i(12'd1, 5'd1, 3'd0, 5'd1), 0, 0, 0, acc);
        check_eq("after_lw_accept", 32'(acc), 1);
        step(1, 0, 0, 1, 5'd0, 32'd5, acc);
        step(1, 1, enc_i(12'd0, 5'd0, 3'd0, 5'd5), 0, 0, 0, acc);
        @(posedge clock); #1;
        check_eq("x0_reads_zero", bus.register_data_1, 0);

        // Reset while SUB is stalled; afterwards it issues at once with zero operands
        step(1, 1, Sub, 0, 0, 0, acc);
        step(0, 1, Sub, 0, 0, 0, acc);
        step(1, 1, Sub, 0, 0, 0, acc);
        check_eq("sub_after_reset", 32'(acc), 1);
        @(posedge clock); #1;
        check_eq("sub_after_reset_rd1", bus.register_data_1, 0);
        check_eq("sub_after_reset_rd2", bus.register_data_2, 0);

        // Random traffic; the bench plays the ALU, returning results in any order
        hold = 0;
        prev_w = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) != 0);
            v   = ($urandom_range(0, 3) != 0);
            if (hold && $urandom_range(0, 9) < 7) w = prev_w;
            else w = rand_instr();
            we = 0;
            wr = 0;
            wd = $urandom;
            if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
                idx = int'($urandom_range(0, inflight.size() - 1));
                we  = 1;
                wr  = inflight[idx];
                inflight.delete(idx);
            end else if ($urandom_range(0, 7) == 0) begin
                we = 1;
                wr = 5'($urandom_range(0, 31));
            end
            step(rst, v, w, we, wr, wd, acc);
            hold   = v && !acc;
            prev_w = w;
        end
        step(1, 0, 0, 0, 0, 0, acc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
